addsign_arb: RTL
================

ADDSIGN_ARB -- requirements
Module: addsign_arb

Interface
REQ-001 Parameter W, default 32: operand and result width; sign bit is bit W-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0  input  1  requester 0 has an operation pending.
REQ-005 opa0, opb0  input  W each  requester 0 operands; valid while req0=1.
REQ-006 gnt0  output  1  combinational; operands of requester 0 are captured at this edge.
REQ-007 req1, opa1, opb1, gnt1: same as REQ-004..006, for requester 1.
REQ-008 out_valid  output  1  result register holds a valid result.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 out  output  W  result; bits W-1:1 always 0, bit 0 = merge result y.
REQ-011 out_id  output  1  requester that issued the current result.
REQ-012 done_cnt  output  16  count of results accepted by the consumer (out_valid & out_ready).

Function
REQ-013 Two-stage pipeline: stage S1 (operand regs opa_r, opb_r, id, s1_valid), stage S2 (out, out_id, out_valid).
REQ-014 adv = !out_valid | out_ready; S1 moves to S2 on the edge where adv=1.
  - Under the same condition, S1 is loaded from the granted requester, or s1_valid is cleared if none is granted.
REQ-015 Grants go only when adv=1; at most one of gnt0/gnt1 is high; gnt never goes high without the matching req.
REQ-016 Round-robin pointer last_id: on a collision, grant the requester other than last_id; last_id updates to the granted id on each grant.
REQ-017 A lone requester is granted on every cycle with adv=1, back-to-back, with no bubbles.
REQ-018 Merge computation on S1, all combinational:
  - sum = (opa_r + opb_r) mod 2^W; sticky = sum[0].
  - sa = opa_r[W-1], sb = opb_r[W-1].
  - {sa,sb}=00 -> y=0; 01 -> y=sticky; 10 or 11 -> y=!sticky.
REQ-019 Latency: grant at edge E0 -> out_valid=1 with the result after edge E1 (when adv=1 at E1); results return in grant order.
REQ-020 Backpressure: if out_valid=1 and out_ready=0, then out, out_id and S1 hold and no grant is issued; no result is dropped or duplicated.
REQ-021 Full pipeline (s1_valid=1, out_valid=1, out_ready=1): S2 takes S1 and S1 takes a new grant in the same edge.
REQ-022 S2 empty with s1_valid=0 (edge where adv=1): out_valid goes to 0; out and out_id hold their last values.
REQ-023 done_cnt increments by 1 per accepted result; it wraps from 0xFFFF to 0x0000.
REQ-024 Requesters drop req only after seeing their gnt; a req held without gnt stalls and is not lost.

Reset
REQ-025 rst_n=0 immediately forces, regardless of clk:
  - s1_valid=0, out_valid=0, out=0, out_id=0, done_cnt=0.
  - last_id=1, so requester 0 wins the first collision.
REQ-026 Reset mid-operation discards in-flight S1/S2 contents; after release, no stale result appears.
REQ-027 gnt0=gnt1=0 while rst_n=0.
REQ-028 The first grant may occur on the first rising edge after rst_n deasserts.

Verification
REQ-029 Single op, out_ready=1: req0, opa0=0x00000001, opb0=0x80000002 (signs 01, sum 0x80000003) -> out=0x00000001, out_id=0, two edges after grant; done_cnt=1.
REQ-030 Sign cases via req1:
  - 0x80000000+0x00000001 -> out=0.
  - 0x00000003+0x00000005 -> out=0.
  - 0xFFFFFFFF+0xFFFFFFFF (wraps to 0xFFFFFFFE) -> out=1.
REQ-031 Collision: req0 and req1 both held for 4 cycles after reset -> grant order 0,1,0,1; out_id sequence 0,1,0,1.
REQ-032 Backpressure: out_ready=0 for 5 cycles with both stages full -> no grants, out stable; on out_ready=1, results drain in order with none lost.
REQ-033 Reset mid-stream: assert rst_n=0 while out_valid=1 -> out_valid=0, out=0, done_cnt=0 immediately; after release, the first collision grants requester 0.
REQ-034 Counter wrap: 65537 accepted results -> done_cnt=0x0001.

Source files
------------

// File: rtl/addsign_arb.sv
// addsign_arb: two-requester round-robin arbiter feeding a two-stage
// sign-merge pipeline. Stage S1 holds the granted operands; the merge
// result y is formed combinationally from S1 and registered into S2.
module addsign_arb #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [W-1:0] opa0,
    input  logic [W-1:0] opb0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [W-1:0] opa1,
    input  logic [W-1:0] opb1,
    output logic         gnt1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         out_id,
    output logic [15:0]  done_cnt
);

    // S1 stage
    logic         s1_valid;
    logic [W-1:0] opa_r;
    logic [W-1:0] opb_r;
    logic         id_r;

    // Round-robin pointer: id of the most recent grant
    logic         last_id;

    logic         adv;
    logic         any_gnt;
    logic         gnt_id;
    logic [W-1:0] sel_opa;
    logic [W-1:0] sel_opb;

    logic [W-1:0] sum;
    logic         sticky;
    logic         sa;
    logic         sb;
    logic         y;

    // Only the LSB of the sum feeds the merge
    logic         unused_sum;
    assign unused_sum = ^sum[W-1:1];

    // Pipeline advances when S2 is empty or being drained this cycle
    assign adv = !out_valid || out_ready;

    // Arbitration: grant only on advance, alternate on collision, never during reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && adv) begin
            if (req0 && req1) begin
                if (last_id) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign any_gnt = gnt0 || gnt1;
    assign gnt_id  = gnt1;
    assign sel_opa = gnt1 ? opa1 : opa0;
    assign sel_opb = gnt1 ? opb1 : opb0;

    // Merge computation on the S1 operands
    always_comb begin
        sum    = opa_r + opb_r;
        sticky = sum[0];
        sa     = opa_r[W-1];
        sb     = opb_r[W-1];
        y      = 1'b0;
        case ({sa, sb})
            2'b00:   y = 1'b0;
            2'b01:   y = sticky;
            default: y = !sticky;
        endcase
    end

    // S1 load from the granted requester, or empty when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            opa_r    <= '0;
            opb_r    <= '0;
            id_r     <= 1'b0;
        end else if (adv) begin
            s1_valid <= any_gnt;
            if (any_gnt) begin
                opa_r <= sel_opa;
                opb_r <= sel_opb;
                id_r  <= gnt_id;
            end
        end
    end

    // Round-robin pointer; reset to 1 so requester 0 wins the first collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id <= 1'b1;
        end else if (any_gnt) begin
            last_id <= gnt_id;
        end
    end

    // S2 result register; payload holds its last value when S1 is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_id    <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out    <= {{(W-1){1'b0}}, y};
                out_id <= id_r;
            end
        end
    end

    // Accepted-result counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end

endmodule
